// File: rtl/mips_div_unit.sv
// ---------------------------------------------------------------------------
// mips_div_unit
//   Multi-cycle radix-2 restoring divider for the EX stage. Executes MIPS
//   DIV (signed) and DIVU (unsigned); quotient goes to LO, remainder to HI.
//   One shift/subtract iteration per clock, P_NBITS iterations per divide.
//
//   Optional build macro: DIV_EARLY_ZERO_EN
//     When defined, a zero divisor skips the iteration phase and the
//     divide-by-zero result is available one cycle after start.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request a divide (only honoured in IDLE)
//   is_signed  1 = DIV, 0 = DIVU (sampled with start)
//   annul      synchronous abort of any in-flight divide
//   a, b       dividend / divisor (sampled with start)
//   busy       high while in RUN or DONE
//   stall      pipeline freeze, drives en = ~stall of ID/EX and EX/MEM
//   valid      one-cycle result strobe
//   quotient   registered LO result
//   remainder  registered HI result
// ---------------------------------------------------------------------------
module mips_div_unit #(
  parameter int P_NBITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic               annul,
  input  logic [P_NBITS-1:0] a,
  input  logic [P_NBITS-1:0] b,
  output logic               busy,
  output logic               stall,
  output logic               valid,
  output logic [P_NBITS-1:0] quotient,
  output logic [P_NBITS-1:0] remainder
);

  localparam int CW = $clog2(P_NBITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(P_NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's complement negation of a result-width value.
  function automatic logic [P_NBITS-1:0] twos_neg(input logic [P_NBITS-1:0] v);
    return ~v + P_NBITS'(1);
  endfunction

  state_t               state_r;
  state_t               state_s;
  logic [CW-1:0]        cnt_r;
  logic [P_NBITS:0]     prem_r;      // partial remainder, one guard bit
  logic [P_NBITS-1:0]   quo_r;       // dividend shifts out, quotient shifts in
  logic [P_NBITS-1:0]   dvs_r;       // divisor magnitude
  logic                 q_neg_r;
  logic                 r_neg_r;
  logic                 dz_r;
  logic [P_NBITS-1:0]   a_orig_r;
  logic [P_NBITS-1:0]   quotient_r;
  logic [P_NBITS-1:0]   remainder_r;

  logic                 a_neg_s;
  logic                 b_neg_s;
  logic                 b_zero_s;
  logic [P_NBITS-1:0]   a_mag_s;
  logic [P_NBITS-1:0]   b_mag_s;
  logic [P_NBITS+1:0]   shl_s;
  logic [P_NBITS+1:0]   diff_s;
  logic                 fits_s;
  logic [P_NBITS:0]     prem_nx_s;
  logic [P_NBITS-1:0]   quo_nx_s;
  logic [P_NBITS-1:0]   quo_fin_s;
  logic [P_NBITS-1:0]   rem_fin_s;

  // Operand magnitudes and signs; -2^(N-1) negates onto itself, which is the
  // correct unsigned magnitude.
  always_comb begin
    a_neg_s  = is_signed & a[P_NBITS-1];
    b_neg_s  = is_signed & b[P_NBITS-1];
    b_zero_s = (b == {P_NBITS{1'b0}});
    if (a_neg_s) begin
      a_mag_s = twos_neg(a);
    end else begin
      a_mag_s = a;
    end
    if (b_neg_s) begin
      b_mag_s = twos_neg(b);
    end else begin
      b_mag_s = b;
    end
  end

  // One restoring step plus sign correction of the step's outcome, used on
  // the final iteration.
  always_comb begin
    shl_s     = {prem_r, quo_r[P_NBITS-1]};
    diff_s    = shl_s - {2'b00, dvs_r};
    fits_s    = ~diff_s[P_NBITS+1];
    quo_nx_s  = {quo_r[P_NBITS-2:0], fits_s};
    if (fits_s) begin
      prem_nx_s = diff_s[P_NBITS:0];
    end else begin
      prem_nx_s = shl_s[P_NBITS:0];
    end
    if (dz_r) begin
      quo_fin_s = {P_NBITS{1'b1}};
      rem_fin_s = a_orig_r;
    end else begin
      if (q_neg_r) begin
        quo_fin_s = twos_neg(quo_nx_s);
      end else begin
        quo_fin_s = quo_nx_s;
      end
      if (r_neg_r) begin
        rem_fin_s = twos_neg(prem_nx_s[P_NBITS-1:0]);
      end else begin
        rem_fin_s = prem_nx_s[P_NBITS-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; annul returns to IDLE from anywhere.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start && !annul) begin
`ifdef DIV_EARLY_ZERO_EN
          if (b_zero_s) begin
            state_s = S_DONE;
          end else begin
            state_s = S_RUN;
          end
`else
          state_s = S_RUN;
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (annul) begin
          state_s = S_IDLE;
        end else if (cnt_r == LAST_CNT) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= CW'(0);
      prem_r      <= {(P_NBITS+1){1'b0}};
      quo_r       <= {P_NBITS{1'b0}};
      dvs_r       <= {P_NBITS{1'b0}};
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      dz_r        <= 1'b0;
      a_orig_r    <= {P_NBITS{1'b0}};
      quotient_r  <= {P_NBITS{1'b0}};
      remainder_r <= {P_NBITS{1'b0}};
    end else if (annul) begin
      // Abort keeps the last completed result visible.
      cnt_r <= CW'(0);
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cnt_r    <= CW'(0);
            prem_r   <= {(P_NBITS+1){1'b0}};
            quo_r    <= a_mag_s;
            dvs_r    <= b_mag_s;
            q_neg_r  <= a_neg_s ^ b_neg_s;
            r_neg_r  <= a_neg_s;
            dz_r     <= b_zero_s;
            a_orig_r <= a;
`ifdef DIV_EARLY_ZERO_EN
            if (b_zero_s) begin
              quotient_r  <= {P_NBITS{1'b1}};
              remainder_r <= a;
            end
`endif
          end
        end
        S_RUN: begin
          prem_r <= prem_nx_s;
          quo_r  <= quo_nx_s;
          if (cnt_r == LAST_CNT) begin
            cnt_r       <= CW'(0);
            quotient_r  <= quo_fin_s;
            remainder_r <= rem_fin_s;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_DONE: begin
          cnt_r <= CW'(0);
        end
        default: begin
          cnt_r <= CW'(0);
        end
      endcase
    end
  end

  // Status outputs are decoded from the state register; stall also reacts to
  // a same-cycle start so the front of the pipeline freezes immediately.
  assign busy      = (state_r == S_RUN) || (state_r == S_DONE);
  assign stall     = ((state_r == S_IDLE) && start && !annul) || (state_r == S_RUN);
  assign valid     = (state_r == S_DONE) && !annul;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;

endmodule

// File: tb/tb_mips_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_div_unit
//   Self-checking bench for mips_div_unit (P_NBITS = 32). A latency/arith
//   model predicts busy, stall, valid, quotient and remainder every cycle;
//   directed cases pin the model with hand-computed values; a random phase
//   mixes starts, annuls, resets and corner operands.
// ---------------------------------------------------------------------------
module tb_mips_div_unit;
  localparam int N = 32;
`ifdef DIV_EARLY_ZERO_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, stall, valid;
  logic [31:0] quotient, remainder;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  mips_div_unit #(.P_NBITS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .annul(annul),
    .a(a), .b(b), .busy(busy), .stall(stall), .valid(valid),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic: SV integer division truncates toward zero, which
  // matches MIPS DIV semantics.
  function automatic void ref_div(input bit s, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sx, sy;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = 32'(sx / sy);
      r  = 32'(sx % sy);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Model: age = cycles since accepted start (0 = idle), lat = cycle of valid.
  int          age = 0;
  int          lat = N + 1;
  int          n_done = 0;
  logic [31:0] pq = 32'd0, pr = 32'd0, eq = 32'd0, er = 32'd0;
  logic        e_busy, e_stall, e_valid;

  always @(negedge clk) begin
    if (age == 0) begin
      e_busy  = 1'b0;
      e_valid = 1'b0;
      e_stall = start & ~annul;
    end else begin
      e_busy  = 1'b1;
      e_valid = (age == lat) && !annul;
      e_stall = (age < lat);
    end
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("stall", {31'd0, stall}, {31'd0, e_stall});
      check("valid", {31'd0, valid}, {31'd0, e_valid});
      check("quotient", quotient, eq);
      check("remainder", remainder, er);
    end
    if (rst) begin
      age = 0;
      eq  = 32'd0;
      er  = 32'd0;
    end else if (annul) begin
      age = 0;
    end else if (age == 0) begin
      if (start) begin
        ref_div(is_signed, a, b, pq, pr);
        lat = (EARLY && b == 32'd0) ? 1 : N + 1;
        age = 1;
      end
    end else if (age == lat) begin
      age = 0;
    end else begin
      age++;
    end
    if (!rst && age != 0 && age == lat) begin
      eq = pq;
      er = pr;
      n_done++;
    end
  end

  // One divide; counts cycles from start (cycle 0) to the valid pulse.
  task automatic do_div(input bit s, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] xq, input logic [31:0] xr,
                        input int xlat, input string name);
    int c;
    bit got;
    @(posedge clk); #1;
    start = 1'b1; is_signed = s; a = av; b = bv;
    c = 0;
    got = 1'b0;
    while (!got && c < 80) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        start = 1'b0;
        c++;
      end
    end
    start = 1'b0;
    check({name, "_lat"}, c, xlat);
    check({name, "_q"}, quotient, xq);
    check({name, "_r"}, remainder, xr);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);

    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_100_7");
    @(posedge clk); #1;
    @(negedge clk);
    check("divu_busy_after", {31'd0, busy}, 32'd0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_m7_2");
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33, "divu_ff_16");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, "div_min_m1");
    do_div(1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 33, "div_min_1");
    do_div(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678,
           EARLY ? 1 : 33, "div_by_zero");

    // Annul in cycle 10 of a DIVU 100/7.
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd7;
    repeat (10) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    check("annul_busy", {31'd0, busy}, 32'd0);
    check("annul_stall", {31'd0, stall}, 32'd0);
    check("annul_hold_q", quotient, 32'hFFFF_FFFF);
    check("annul_hold_r", remainder, 32'h1234_5678);
    do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, "after_annul");

    // Reset in cycle 5 of a divide.
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd9;
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);

    // start together with annul in IDLE is ignored.
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; a = 32'd50; b = 32'd5;
    @(negedge clk);
    check("start_annul_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    check("start_annul_busy", {31'd0, busy}, 32'd0);

    // Random traffic against the model.
    n_done = 0;
    repeat (6000) begin
      @(posedge clk); #1;
      start     = ($urandom_range(0, 3) == 0);
      annul     = ($urandom_range(0, 99) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      is_signed = 1'($urandom_range(0, 1));
      a         = rand_operand();
      b         = rand_operand();
    end
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0; rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("random_completions", {31'd0, (n_done >= 20)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
